// File: rtl/i2s_capture_ctrl_if.sv
// Bus bundle between the capture sequencer, the I2S receiver, the frame RAM and the spectrum engine.
// Optional decim_i exists only when CAPTURE_DECIMATION_EN is defined.
interface i2s_capture_ctrl_if #(
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned FRAME_LEN  = 256
`ifdef CAPTURE_DECIMATION_EN
    , parameter int unsigned DECIM_BITS = 4
`endif
);
    localparam int unsigned IDX_BITS = $clog2(FRAME_LEN);

    logic                 start_i;
    logic                 stop_i;
    logic                 continuous_i;
    logic [1:0]           ch_sel_i;
    logic                 i2s_get_o;
    logic                 i2s_done_i;
    logic [DATA_BITS-1:0] i2s_sample_data_L_i;
    logic [DATA_BITS-1:0] i2s_sample_data_R_i;
    logic                 buf_we_o;
    logic [IDX_BITS:0]    buf_addr_o;
    logic [DATA_BITS-1:0] buf_data_o;
    logic                 frame_valid_o;
    logic                 frame_bank_o;
    logic                 frame_ack_i;
    logic                 busy_o;
    logic                 overrun_o;
`ifdef CAPTURE_DECIMATION_EN
    logic [DECIM_BITS-1:0] decim_i;
`endif

    // Host / receiver / consumer side
    modport master (
`ifdef CAPTURE_DECIMATION_EN
        output decim_i,
`endif
        output start_i, stop_i, continuous_i, ch_sel_i, i2s_done_i,
               i2s_sample_data_L_i, i2s_sample_data_R_i, frame_ack_i,
        input  i2s_get_o, buf_we_o, buf_addr_o, buf_data_o,
               frame_valid_o, frame_bank_o, busy_o, overrun_o
    );

    // Capture sequencer side
    modport slave (
`ifdef CAPTURE_DECIMATION_EN
        input  decim_i,
`endif
        input  start_i, stop_i, continuous_i, ch_sel_i, i2s_done_i,
               i2s_sample_data_L_i, i2s_sample_data_R_i, frame_ack_i,
        output i2s_get_o, buf_we_o, buf_addr_o, buf_data_o,
               frame_valid_o, frame_bank_o, busy_o, overrun_o
    );
endinterface

// File: rtl/i2s_capture_ctrl.sv
// I2S capture sequencer: writes FRAME_LEN-sample frames into a ping-pong RAM and hands banks off via valid/ack.
// Define CAPTURE_DECIMATION_EN to add decim_i sample decimation.
module i2s_capture_ctrl #(
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned FRAME_LEN  = 256
`ifdef CAPTURE_DECIMATION_EN
    , parameter int unsigned DECIM_BITS = 4
`endif
) (
    input logic               clk,
    input logic               rst_n,
    i2s_capture_ctrl_if.slave bus
);
    localparam int unsigned IDX_BITS = $clog2(FRAME_LEN);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] STALL   = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_LEN - 1);

    logic [1:0]           r_state, w_state_nxt;
    logic                 r_wr_bank, w_wr_bank_nxt;
    logic                 r_rd_bank, w_rd_bank_nxt;
    logic [IDX_BITS-1:0]  r_wr_idx, w_wr_idx_nxt;
    logic [1:0]           r_bank_full, w_bank_full_nxt;
    logic                 r_cont, w_cont_nxt;
    logic [1:0]           r_ch_sel, w_ch_sel_nxt;
    logic                 r_overrun, w_overrun_nxt;
    logic                 r_we, w_we_nxt;
    logic [IDX_BITS:0]    r_addr, w_addr_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_get, r_valid, r_fbank, r_busy;
    logic [DATA_BITS:0]   w_sum;
    logic [DATA_BITS-1:0] w_sample;
    logic                 w_ack_ok;
    logic                 w_take;

`ifdef CAPTURE_DECIMATION_EN
    logic [DECIM_BITS-1:0] r_decim, w_decim_nxt;
    logic [DECIM_BITS-1:0] r_skip, w_skip_nxt;
    assign w_take = (r_skip == '0);
`else
    assign w_take = 1'b1;
`endif

    assign w_ack_ok = bus.frame_ack_i && r_bank_full[r_rd_bank];

    // Channel select; the mix is a sign-extended sum halved by arithmetic shift
    always_comb begin
        w_sum = {bus.i2s_sample_data_L_i[DATA_BITS-1], bus.i2s_sample_data_L_i}
              + {bus.i2s_sample_data_R_i[DATA_BITS-1], bus.i2s_sample_data_R_i};
        case (r_ch_sel)
            2'b01:   w_sample = bus.i2s_sample_data_R_i;
            2'b10:   w_sample = DATA_BITS'(w_sum >> 1);
            default: w_sample = bus.i2s_sample_data_L_i;
        endcase
    end

    // Next-state and datapath; ack is applied before frame completion so both land together
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_bank_nxt   = r_wr_bank;
        w_rd_bank_nxt   = r_rd_bank;
        w_wr_idx_nxt    = r_wr_idx;
        w_bank_full_nxt = r_bank_full;
        w_cont_nxt      = r_cont;
        w_ch_sel_nxt    = r_ch_sel;
        w_overrun_nxt   = r_overrun;
        w_we_nxt        = 1'b0;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
`ifdef CAPTURE_DECIMATION_EN
        w_decim_nxt     = r_decim;
        w_skip_nxt      = r_skip;
`endif

        if (w_ack_ok) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
            w_rd_bank_nxt              = ~r_rd_bank;
        end

        case (r_state)
            IDLE: begin
                if (bus.start_i && !bus.stop_i) begin
                    w_cont_nxt    = bus.continuous_i;
                    w_ch_sel_nxt  = bus.ch_sel_i;
                    w_overrun_nxt = 1'b0;
                    w_state_nxt   = CAPTURE;
`ifdef CAPTURE_DECIMATION_EN
                    w_decim_nxt   = bus.decim_i;
                    w_skip_nxt    = '0;
`endif
                end
            end
            CAPTURE, STALL: begin
                if (bus.stop_i) begin
                    w_wr_idx_nxt = '0;
                    w_state_nxt  = (|w_bank_full_nxt) ? DRAIN : IDLE;
`ifdef CAPTURE_DECIMATION_EN
                    w_skip_nxt   = '0;
`endif
                end else begin
                    if (bus.i2s_done_i) begin
`ifdef CAPTURE_DECIMATION_EN
                        w_skip_nxt = (r_skip == r_decim) ? '0 : r_skip + DECIM_BITS'(1);
`endif
                        if (r_state == CAPTURE && w_take) begin
                            w_we_nxt   = 1'b1;
                            w_addr_nxt = {r_wr_bank, r_wr_idx};
                            w_data_nxt = w_sample;
                            if (r_wr_idx == LAST_IDX) begin
                                w_bank_full_nxt[r_wr_bank] = 1'b1;
                                w_wr_idx_nxt               = '0;
                                w_wr_bank_nxt              = ~r_wr_bank;
                                if (!r_cont) begin
                                    w_state_nxt = DRAIN;
                                end else if (w_bank_full_nxt[~r_wr_bank]) begin
                                    w_state_nxt = STALL;
                                end
                            end else begin
                                w_wr_idx_nxt = r_wr_idx + IDX_BITS'(1);
                            end
                        end else if (r_state == STALL && w_take) begin
                            w_overrun_nxt = 1'b1;
                        end
                    end
                    if (r_state == STALL && !w_bank_full_nxt[r_wr_bank]) begin
                        w_state_nxt  = CAPTURE;
                        w_wr_idx_nxt = '0;
`ifdef CAPTURE_DECIMATION_EN
                        w_skip_nxt   = '0;
`endif
                    end
                end
            end
            default: begin
                if (w_bank_full_nxt == 2'b00) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_bank_full <= 2'b00;
            r_cont      <= 1'b0;
            r_ch_sel    <= 2'b00;
            r_overrun   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_get       <= 1'b0;
            r_valid     <= 1'b0;
            r_fbank     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef CAPTURE_DECIMATION_EN
            r_decim     <= '0;
            r_skip      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
            r_bank_full <= w_bank_full_nxt;
            r_cont      <= w_cont_nxt;
            r_ch_sel    <= w_ch_sel_nxt;
            r_overrun   <= w_overrun_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_get       <= (w_state_nxt == CAPTURE) || (w_state_nxt == STALL);
            r_valid     <= w_bank_full_nxt[w_rd_bank_nxt];
            r_fbank     <= w_rd_bank_nxt;
            r_busy      <= (w_state_nxt != IDLE);
`ifdef CAPTURE_DECIMATION_EN
            r_decim     <= w_decim_nxt;
            r_skip      <= w_skip_nxt;
`endif
        end
    end

    assign bus.i2s_get_o     = r_get;
    assign bus.buf_we_o      = r_we;
    assign bus.buf_addr_o    = r_addr;
    assign bus.buf_data_o    = r_data;
    assign bus.frame_valid_o = r_valid;
    assign bus.frame_bank_o  = r_fbank;
    assign bus.busy_o        = r_busy;
    assign bus.overrun_o     = r_overrun;
endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl: frame/ack count model checked every cycle, plus literal expectations per scenario.
// Decimation scenario runs only when CAPTURE_DECIMATION_EN is defined.
module tb_i2s_capture_ctrl;
    localparam int unsigned DB     = 16;
    localparam int unsigned FL     = 4;
    localparam int unsigned ADDR_W = $clog2(FL) + 1;
    localparam int M_IDLE = 0, M_CAP = 1, M_STALL = 2, M_DRAIN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef CAPTURE_DECIMATION_EN
    i2s_capture_ctrl_if #(.DATA_BITS(DB), .FRAME_LEN(FL), .DECIM_BITS(4)) bus ();
    i2s_capture_ctrl #(.DATA_BITS(DB), .FRAME_LEN(FL), .DECIM_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`else
    i2s_capture_ctrl_if #(.DATA_BITS(DB), .FRAME_LEN(FL)) bus ();
    i2s_capture_ctrl #(.DATA_BITS(DB), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames completed and acks taken are counters; banks follow from their parity
    int   m_mode, m_filled, m_frames, m_acks, m_pulses, m_dec;
    logic m_cont, m_over, m_take, m_was_stall;
    logic [1:0] m_sel;
    logic exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DB-1:0]     exp_data;

    function automatic logic [DB-1:0] mdl_sample(input logic [1:0] sel, input logic [DB-1:0] l,
                                                  input logic [DB-1:0] r);
        int sl, sr, s;
        sl = int'($signed(l));
        sr = int'($signed(r));
        s  = (sl + sr) >>> 1;
        if (sel == 2'b01) return r;
        if (sel == 2'b10) return DB'(s);
        return l;
    endfunction

    always @(posedge clk) begin
        exp_we = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_filled = 0; m_frames = 0; m_acks = 0; m_pulses = 0; m_dec = 0;
            m_cont = 1'b0; m_over = 1'b0; m_sel = 2'b00;
        end else begin
            if (bus.frame_ack_i && (m_frames - m_acks) > 0) m_acks++;
            m_was_stall = (m_mode == M_STALL);
            case (m_mode)
                M_IDLE: if (bus.start_i && !bus.stop_i) begin
                    m_cont = bus.continuous_i; m_sel = bus.ch_sel_i; m_over = 1'b0;
                    m_mode = M_CAP; m_pulses = 0;
`ifdef CAPTURE_DECIMATION_EN
                    m_dec = int'(bus.decim_i);
`else
                    m_dec = 0;
`endif
                end
                M_CAP, M_STALL: begin
                    if (bus.stop_i) begin
                        m_filled = 0;
                        m_mode = (m_frames != m_acks) ? M_DRAIN : M_IDLE;
                    end else begin
                        if (bus.i2s_done_i) begin
                            m_take = ((m_pulses % (m_dec + 1)) == 0);
                            m_pulses++;
                            if (m_mode == M_CAP && m_take) begin
                                exp_we   = 1'b1;
                                exp_addr = ADDR_W'((m_frames % 2) * FL + m_filled);
                                exp_data = mdl_sample(m_sel, bus.i2s_sample_data_L_i, bus.i2s_sample_data_R_i);
                                m_filled++;
                                if (m_filled == FL) begin
                                    m_filled = 0;
                                    m_frames++;
                                    if (!m_cont) m_mode = M_DRAIN;
                                    else if (m_frames - m_acks == 2) m_mode = M_STALL;
                                end
                            end else if (m_mode == M_STALL && m_take) begin
                                m_over = 1'b1;
                            end
                        end
                        if (m_was_stall && (m_frames - m_acks) < 2) begin
                            m_mode = M_CAP; m_pulses = 0;
                        end
                    end
                end
                default: if (m_frames == m_acks) m_mode = M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model, plus a log of observed writes
    logic [ADDR_W-1:0] wlog_addr[$];
    logic [DB-1:0]     wlog_data[$];

    always @(negedge clk) begin
        chk("buf_we", 32'(bus.buf_we_o), 32'(exp_we));
        if (exp_we) begin
            chk("buf_addr", 32'(bus.buf_addr_o), 32'(exp_addr));
            chk("buf_data", 32'(bus.buf_data_o), 32'(exp_data));
        end
        if (bus.buf_we_o === 1'b1) begin
            wlog_addr.push_back(bus.buf_addr_o);
            wlog_data.push_back(bus.buf_data_o);
        end
        chk("i2s_get", 32'(bus.i2s_get_o), 32'(m_mode == M_CAP || m_mode == M_STALL));
        chk("busy", 32'(bus.busy_o), 32'(m_mode != M_IDLE));
        chk("frame_valid", 32'(bus.frame_valid_o), 32'((m_frames - m_acks) > 0));
        chk("frame_bank", 32'(bus.frame_bank_o), 32'(m_acks % 2));
        chk("overrun", 32'(bus.overrun_o), 32'(m_over));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DB-1:0] l, input logic [DB-1:0] r);
        bus.i2s_done_i = 1'b1; bus.i2s_sample_data_L_i = l; bus.i2s_sample_data_R_i = r;
        tick(1);
        bus.i2s_done_i = 1'b0;
        tick(1);
    endtask

    task automatic do_start(input logic cont, input logic [1:0] sel, input logic with_stop);
        bus.start_i = 1'b1; bus.stop_i = with_stop; bus.continuous_i = cont; bus.ch_sel_i = sel;
        tick(1);
        bus.start_i = 1'b0; bus.stop_i = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop_i = 1'b1; tick(1); bus.stop_i = 1'b0;
    endtask

    task automatic do_ack();
        bus.frame_ack_i = 1'b1; tick(1); bus.frame_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
        wlog_addr.delete(); wlog_data.delete();
    endtask

    initial begin
        bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.continuous_i = 1'b0; bus.ch_sel_i = 2'b00;
        bus.i2s_done_i = 1'b0; bus.i2s_sample_data_L_i = '0; bus.i2s_sample_data_R_i = '0;
        bus.frame_ack_i = 1'b0;
`ifdef CAPTURE_DECIMATION_EN
        bus.decim_i = '0;
`endif
        do_reset();
        chk("rst_get", 32'(bus.i2s_get_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_valid", 32'(bus.frame_valid_o), 32'd0);
        chk("rst_we", 32'(bus.buf_we_o), 32'd0);

        // Single-frame left capture
        do_start(1'b0, 2'b00, 1'b0);
        chk("s1_get_on", 32'(bus.i2s_get_o), 32'd1);
        for (int i = 1; i <= 4; i++) send(DB'(i), 16'h0055);
        tick(2);
        chk("s1_nwr", 32'(wlog_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("s1_addr", 32'(wlog_addr[i]), 32'(i));
            chk("s1_data", 32'(wlog_data[i]), 32'(i + 1));
        end
        chk("s1_valid", 32'(bus.frame_valid_o), 32'd1);
        chk("s1_bank", 32'(bus.frame_bank_o), 32'd0);
        chk("s1_get_off", 32'(bus.i2s_get_o), 32'd0);
        send(16'h0BAD, 16'h0BAD);
        do_stop();
        do_start(1'b1, 2'b01, 1'b0);
        chk("s1_drain_busy", 32'(bus.busy_o), 32'd1);
        do_ack();
        tick(1);
        chk("s1_idle", 32'(bus.busy_o), 32'd0);
        chk("s1_valid_clr", 32'(bus.frame_valid_o), 32'd0);

        // Mixed channel, including a stray ack with nothing to release
        do_reset();
        do_start(1'b0, 2'b10, 1'b0);
        send(16'h8000, 16'h7FFF);
        send(16'h0004, 16'h0002);
        do_ack();
        send(16'h7FFF, 16'h7FFF);
        tick(2);
        chk("mix_data0", 32'(wlog_data[0]), 32'h0000FFFF);
        chk("mix_data1", 32'(wlog_data[1]), 32'h00000003);
        chk("mix_data2", 32'(wlog_data[2]), 32'h00007FFF);
        chk("mix_bank", 32'(bus.frame_bank_o), 32'd0);
        do_stop();
        tick(1);

        // Continuous ping-pong on the right channel
        do_reset();
        do_start(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h1111, DB'(16'h20 + i));
        chk("pp_bank0", 32'(bus.frame_bank_o), 32'd0);
        do_ack();
        for (int i = 4; i < 8; i++) send(16'h1111, DB'(16'h20 + i));
        tick(2);
        for (int i = 0; i < 8; i++) chk("pp_addr", 32'(wlog_addr[i]), 32'(i));
        chk("pp_data7", 32'(wlog_data[7]), 32'h27);
        chk("pp_bank1", 32'(bus.frame_bank_o), 32'd1);
        chk("pp_valid", 32'(bus.frame_valid_o), 32'd1);
        chk("pp_overrun", 32'(bus.overrun_o), 32'd0);
        do_stop();
        do_ack();
        tick(1);
        chk("pp_idle", 32'(bus.busy_o), 32'd0);

        // Overrun: no ack, ten pulses
        do_reset();
        do_start(1'b1, 2'b00, 1'b0);
        for (int i = 1; i <= 10; i++) send(DB'(i), 16'h0);
        tick(1);
        chk("ov_nwr", 32'(wlog_addr.size()), 32'd8);
        chk("ov_flag", 32'(bus.overrun_o), 32'd1);
        chk("ov_get", 32'(bus.i2s_get_o), 32'd1);
        do_ack();
        tick(1);
        send(16'h00AA, 16'h0);
        tick(1);
        chk("ov_resume_addr", 32'(wlog_addr[wlog_addr.size() - 1]), 32'd0);
        chk("ov_resume_data", 32'(wlog_data[wlog_data.size() - 1]), 32'h00AA);
        do_stop();
        do_start(1'b0, 2'b00, 1'b0);
        do_stop();
        send(16'h0001, 16'h0);
        chk("ov_drain_busy", 32'(bus.busy_o), 32'd1);
        do_ack();
        tick(1);
        chk("ov_sticky", 32'(bus.overrun_o), 32'd1);

        // Stop mid-frame, start/stop collision, restart from index 0
        do_start(1'b0, 2'b11, 1'b0);
        chk("st_ov_clr", 32'(bus.overrun_o), 32'd0);
        send(16'h000A, 16'h000B);
        send(16'h000C, 16'h000D);
        do_stop();
        chk("st_get", 32'(bus.i2s_get_o), 32'd0);
        chk("st_busy", 32'(bus.busy_o), 32'd0);
        do_start(1'b0, 2'b00, 1'b1);
        chk("st_collide", 32'(bus.busy_o), 32'd0);
        do_start(1'b0, 2'b00, 1'b0);
        send(16'h0011, 16'h0);
        tick(1);
        chk("st_restart_addr", 32'(wlog_addr[wlog_addr.size() - 1]), 32'd0);
        chk("st_sel3_data", 32'(wlog_data[wlog_data.size() - 2]), 32'h000C);
        do_stop();

        // Reset mid-capture with a full bank
        do_start(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) send(DB'(i), 16'h0);
        chk("rc_valid_pre", 32'(bus.frame_valid_o), 32'd1);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        chk("rc_valid", 32'(bus.frame_valid_o), 32'd0);
        chk("rc_get", 32'(bus.i2s_get_o), 32'd0);
        chk("rc_busy", 32'(bus.busy_o), 32'd0);
        chk("rc_we", 32'(bus.buf_we_o), 32'd0);

`ifdef CAPTURE_DECIMATION_EN
        // Decimation by 3: pulses 1, 4, 7, 10 land in the frame
        wlog_addr.delete(); wlog_data.delete();
        bus.decim_i = 4'd2;
        do_start(1'b0, 2'b00, 1'b0);
        for (int i = 1; i <= 12; i++) send(DB'(i), 16'h0);
        tick(1);
        chk("dec_nwr", 32'(wlog_data.size()), 32'd4);
        chk("dec_d0", 32'(wlog_data[0]), 32'd1);
        chk("dec_d1", 32'(wlog_data[1]), 32'd4);
        chk("dec_d2", 32'(wlog_data[2]), 32'd7);
        chk("dec_d3", 32'(wlog_data[3]), 32'd10);
        do_ack();
        tick(1);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/i2s_capture_ctrl.md
Name: i2s_capture_ctrl

Overview:
Capture sequencer between the I2S receiver and the FFT frame buffer. It enables the receiver, selects or mixes the left and right channels, and writes FRAME_LEN-sample frames into a two-bank (ping-pong) buffer RAM. It hands full banks to the spectrum engine through a valid/ack handshake, supporting single-shot and continuous capture with overrun detection.

Parameters:
DATA_BITS, 16, sample width; matches receiver output width
FRAME_LEN, 256, samples per frame; power of two, >= 4
DECIM_BITS, 4, width of decimation factor input (optional feature only)
(localparam IDX_BITS = $clog2(FRAME_LEN))

Ports:
clk  in  1  system clock, same domain as receiver (BCLK)
rst_n  in  1  synchronous active-low reset
start_i  in  1  one-cycle pulse, begin capture
stop_i  in  1  one-cycle pulse, abort capture
continuous_i  in  1  0 = single frame, 1 = continuous; sampled on accepted start
ch_sel_i  in  2  00 = L, 01 = R, 10 = (L+R)/2, 11 = L; sampled on accepted start
i2s_get_o  out  1  receiver enable
i2s_done_i  in  1  receiver pulse: L/R pair valid
i2s_sample_data_L_i  in  DATA_BITS  left sample, signed
i2s_sample_data_R_i  in  DATA_BITS  right sample, signed
buf_we_o  out  1  buffer write strobe
buf_addr_o  out  IDX_BITS+1  {bank, index}
buf_data_o  out  DATA_BITS  sample written
frame_valid_o  out  1  a full bank is available
frame_bank_o  out  1  bank to read while frame_valid_o is high
frame_ack_i  in  1  one-cycle pulse, consumer releases frame_bank_o
busy_o  out  1  state != IDLE
overrun_o  out  1  sticky; samples were dropped

Behaviour:
- Reset (rst_n low at clk edge) sets all outputs to 0, state IDLE, wr_bank 0, rd_bank 0, wr_idx 0, bank_full 00. Reset mid-frame discards all buffered data.
- States: IDLE, CAPTURE, STALL, DRAIN.
- IDLE:
  - An accepted start_i latches mode and ch_sel, clears overrun_o, and goes to CAPTURE.
  - If start_i and stop_i are high in the same cycle, stop wins and the block stays IDLE.
- CAPTURE:
  - i2s_get_o = 1.
  - On i2s_done_i, the next cycle drives buf_we_o = 1, buf_addr_o = {wr_bank, wr_idx}, and buf_data_o = the selected sample. Latency is 1 cycle.
  - Then wr_idx increments.
- Mixing: (L+R) is computed at DATA_BITS+1 sign-extended width, arithmetic-shifted right by 1, and truncated to DATA_BITS. Example: 0x7FFF + 0x7FFF -> 0x7FFF; 0x8000 + 0x7FFF -> 0xFFFF.
- Frame completion (write at wr_idx == FRAME_LEN-1):
  - Set bank_full[wr_bank] and wrap wr_idx to 0.
  - Single mode: go to DRAIN.
  - Continuous mode: toggle wr_bank. If bank_full of the new bank is set (after any same-cycle ack), go to STALL; else stay in CAPTURE.
- STALL:
  - i2s_get_o stays 1.
  - Each i2s_done_i is dropped with no write, and overrun_o is set.
  - When an ack frees wr_bank, return to CAPTURE with wr_idx = 0, keeping frames aligned.
- DRAIN:
  - i2s_get_o = 0.
  - Go to IDLE once bank_full == 00.
- stop_i in CAPTURE or STALL:
  - Deassert i2s_get_o next cycle and discard the partial frame (wr_idx = 0).
  - Go to DRAIN if any bank is full, else IDLE.
  - A write already in its output cycle still completes.
- start_i outside IDLE is ignored. stop_i in IDLE or DRAIN is ignored.
- Handshake:
  - frame_valid_o = bank_full[rd_bank]; frame_bank_o = rd_bank.
  - frame_ack_i while frame_valid_o is high clears bank_full[rd_bank] and toggles rd_bank.
  - frame_ack_i while frame_valid_o is low is ignored.
  - Ack and frame completion in the same cycle are both applied.
  - Banks are delivered strictly in fill order.
- i2s_done_i in IDLE or DRAIN is ignored.

Optional Feature:
Macro CAPTURE_DECIMATION_EN.
- Defined:
  - Adds input decim_i [DECIM_BITS-1:0], latched on accepted start.
  - Only the first of every decim_i+1 i2s_done_i pulses is written; the rest are skipped.
  - The skip counter resets on start, on stop, and on leaving STALL.
  - Skipped pulses in STALL do not set overrun_o; only pulses that would have been written do.
- Undefined: the port is absent and every pulse is written, equivalent to decim_i = 0.

Test Plan:
- Single L capture, FRAME_LEN=4: start with ch_sel=00, continuous=0, then 4 done pulses with L=1..4 -> writes at addr 0..3 with data 1..4, then frame_valid_o=1, frame_bank_o=0, i2s_get_o=0. After ack -> IDLE, busy_o=0.
- Mix: L=0x8000, R=0x7FFF with ch_sel=10 -> buf_data_o=0xFFFF. L=0x0004, R=0x0002 -> 0x0003.
- Continuous ping-pong: 8 done pulses, ack after the first frame -> addrs 0..3 then 4..7. frame_bank_o goes 0 then 1. overrun_o stays 0.
- Overrun: continuous with no ack, 10 pulses -> 8 writes, pulses 9 and 10 dropped, overrun_o=1. An ack then returns to CAPTURE and the next write goes to addr 0.
- Stop mid-frame: stop after 2 writes with no full banks -> IDLE next cycle, i2s_get_o=0. A following start writes from index 0 with overrun_o cleared.
- Reset mid-CAPTURE with a full bank -> all outputs 0, frame_valid_o=0. With CAPTURE_DECIMATION_EN and decim_i=2, 12 pulses -> pulses 1, 4, 7 and 10 are written.
